// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse keyer slice.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MARK,
    SPACE,
    GAP,
    WORD
  } state_t;

  localparam int unsigned DOT_U        = 1;
  localparam int unsigned DASH_U       = 3;
  localparam int unsigned ELEM_GAP_U   = 1;
  localparam int unsigned LETTER_GAP_U = 3;
  localparam int unsigned WORD_EXTRA_U = 4;

  localparam logic [1:0] KIND_INVALID = 2'd0;
  localparam logic [1:0] KIND_SYMBOL  = 2'd1;
  localparam logic [1:0] KIND_SPACE   = 2'd2;

  typedef struct packed {
    logic [2:0] len;
    logic [4:0] bits;
    logic [1:0] kind;
  } pattern_t;

  // Codes are written right-aligned; the keyer consumes them from bits[4] down.
  function automatic pattern_t mk_symbol(input logic [2:0] len, input logic [4:0] code);
    pattern_t p;
    p.len  = len;
    p.bits = code << (3'd5 - len);
    p.kind = KIND_SYMBOL;
    return p;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational ASCII to Morse pattern lookup (1 = dash, 0 = dot).
module morse_rom
  import morse_pkg::*;
(
  input  logic [7:0] ch,
  output pattern_t   pat
);

  logic [7:0] folded;

  always_comb begin
    folded = ch;
    if (ch >= "a" && ch <= "z") folded = ch - 8'd32;

    pat = '{len: '0, bits: '0, kind: KIND_INVALID};
    case (folded)
      "A": pat = mk_symbol(3'd2, 5'b00001);
      "B": pat = mk_symbol(3'd4, 5'b01000);
      "C": pat = mk_symbol(3'd4, 5'b01010);
      "D": pat = mk_symbol(3'd3, 5'b00100);
      "E": pat = mk_symbol(3'd1, 5'b00000);
      "F": pat = mk_symbol(3'd4, 5'b00010);
      "G": pat = mk_symbol(3'd3, 5'b00110);
      "H": pat = mk_symbol(3'd4, 5'b00000);
      "I": pat = mk_symbol(3'd2, 5'b00000);
      "J": pat = mk_symbol(3'd4, 5'b00111);
      "K": pat = mk_symbol(3'd3, 5'b00101);
      "L": pat = mk_symbol(3'd4, 5'b00100);
      "M": pat = mk_symbol(3'd2, 5'b00011);
      "N": pat = mk_symbol(3'd2, 5'b00010);
      "O": pat = mk_symbol(3'd3, 5'b00111);
      "P": pat = mk_symbol(3'd4, 5'b00110);
      "Q": pat = mk_symbol(3'd4, 5'b01101);
      "R": pat = mk_symbol(3'd3, 5'b00010);
      "S": pat = mk_symbol(3'd3, 5'b00000);
      "T": pat = mk_symbol(3'd1, 5'b00001);
      "U": pat = mk_symbol(3'd3, 5'b00001);
      "V": pat = mk_symbol(3'd4, 5'b00001);
      "W": pat = mk_symbol(3'd3, 5'b00011);
      "X": pat = mk_symbol(3'd4, 5'b01001);
      "Y": pat = mk_symbol(3'd4, 5'b01011);
      "Z": pat = mk_symbol(3'd4, 5'b01100);
      "0": pat = mk_symbol(3'd5, 5'b11111);
      "1": pat = mk_symbol(3'd5, 5'b01111);
      "2": pat = mk_symbol(3'd5, 5'b00111);
      "3": pat = mk_symbol(3'd5, 5'b00011);
      "4": pat = mk_symbol(3'd5, 5'b00001);
      "5": pat = mk_symbol(3'd5, 5'b00000);
      "6": pat = mk_symbol(3'd5, 5'b10000);
      "7": pat = mk_symbol(3'd5, 5'b11000);
      "8": pat = mk_symbol(3'd5, 5'b11100);
      "9": pat = mk_symbol(3'd5, 5'b11110);
      " ": pat = '{len: '0, bits: '0, kind: KIND_SPACE};
      default: ;
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// Accepts one character per valid/ready transfer and drives the Morse key envelope.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 5_000_000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iCHAR,
  input  logic       iVALID,
  output logic       oREADY,
  output logic       oKEY,
  output logic       oBUSY,
  output logic       oDONE
);

  localparam int unsigned CNT_W = $clog2(4 * UNIT_CYCLES + 1);

  localparam logic [CNT_W-1:0] DOT_LOAD    = CNT_W'(DOT_U * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LOAD   = CNT_W'(DASH_U * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ELEM_LOAD   = CNT_W'(ELEM_GAP_U * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LETTER_LOAD = CNT_W'(LETTER_GAP_U * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORD_LOAD   = CNT_W'(WORD_EXTRA_U * UNIT_CYCLES - 1);

  state_t           state;
  logic [7:0]       char_q;
  logic [4:0]       bits;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             key;
  logic             done;
  pattern_t         pat;

  morse_rom u_rom (
    .ch  (char_q),
    .pat (pat)
  );

  assign oREADY = (state == IDLE);
  assign oBUSY  = (state != IDLE);
  assign oKEY   = key;
  assign oDONE  = done;

  // key is updated on the same edge as the state so the envelope lines up with MARK exactly.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state  <= IDLE;
      char_q <= '0;
      bits   <= '0;
      idx    <= '0;
      cnt    <= '0;
      key    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iVALID) begin
            char_q <= iCHAR;
            state  <= LOAD;
          end
        end
        LOAD: begin
          case (pat.kind)
            KIND_SYMBOL: begin
              bits  <= pat.bits;
              idx   <= pat.len - 3'd1;
              cnt   <= pat.bits[4] ? DASH_LOAD : DOT_LOAD;
              key   <= 1'b1;
              state <= MARK;
            end
            KIND_SPACE: begin
              cnt   <= WORD_LOAD;
              state <= WORD;
            end
            default: begin
              done  <= 1'b1;
              state <= IDLE;
            end
          endcase
        end
        MARK: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            key <= 1'b0;
            if (idx != '0) begin
              idx   <= idx - 3'd1;
              bits  <= {bits[3:0], 1'b0};
              cnt   <= ELEM_LOAD;
              state <= SPACE;
            end else begin
              cnt   <= LETTER_LOAD;
              state <= GAP;
            end
          end
        end
        SPACE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            key   <= 1'b1;
            cnt   <= bits[4] ? DASH_LOAD : DOT_LOAD;
            state <= MARK;
          end
        end
        GAP, WORD: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
Upstream stage of the Morse sounder: accepts one character per valid/ready transfer, looks up its Morse pattern, and drives a keying envelope oKEY with standard dot/dash/gap timing.
- Feeds the tone stage, which gates its square wave onto oSOUND while oKEY=1.
- Runs on the board clock; timing derives from one "unit" counter.

Parameters:
UNIT_CYCLES, 5_000_000, clock cycles per Morse unit (100 ms at 50 MHz); benches use 4.
CNT_W, $clog2(4*UNIT_CYCLES+1), width of the timing counter (derived; not overridden).

Ports:
iCLK     in   1  system clock, all logic on rising edge
iRST_N   in   1  asynchronous, active-low reset
iCHAR    in   8  ASCII character to send
iVALID   in   1  iCHAR valid
oREADY   out  1  keyer can accept a character (1 only in IDLE)
oKEY     out  1  key envelope: 1 = tone on
oBUSY    out  1  1 in any state other than IDLE
oDONE    out  1  one-cycle pulse when a character (including its trailing gap) is finished

Behaviour:
- Reset (iRST_N=0, async): state=IDLE, oKEY=0, oBUSY=0, oDONE=0, oREADY=1 once reset releases; counter and pattern registers cleared.
- Reset mid-character aborts immediately: oKEY drops asynchronously and the character is discarded.
- Transfer on rising edge where iVALID&&oREADY. iCHAR sampled only then; iCHAR/iVALID ignored while busy.
- Lookup is registered (LOAD state, 1 cycle). Pattern is len[2:0] (1..5) plus bits[4:0], MSB-first, 1=dash, 0=dot.
- Character mapping:
  - 'A'-'Z' and 'a'-'z' map to the same letter (case folded).
  - '0'-'9' are 5-element codes.
  - ' ' is the word gap.
  - Any other code is invalid.
- States and transitions:
  - IDLE: on transfer -> LOAD.
  - LOAD: valid letter/digit -> MARK; ' ' -> WORD; invalid -> IDLE with oDONE pulse (no key activity).
  - MARK: oKEY=1 for 1 unit (dot) or 3 units (dash). Then:
    - elements remain -> SPACE;
    - else -> GAP.
  - SPACE: oKEY=0 for 1 unit, then the next element -> MARK.
  - GAP: oKEY=0 for 3 units (letter gap), then -> IDLE with oDONE.
  - WORD: oKEY=0 for 4 units (3 + 4 = 7-unit word gap after a preceding letter), then -> IDLE with oDONE.
- Timing:
  - oKEY is registered. Transfer at edge k: LOAD occupies k+1, oKEY=1 from edge k+2.
  - A unit is exactly UNIT_CYCLES cycles. The counter loads N*UNIT_CYCLES-1 on state entry and counts down to 0; the state changes on the edge after 0.
- oDONE:
  - Asserted for the single cycle in which the state is IDLE after GAP/WORD/invalid.
  - oREADY=1 in that same cycle, so back-to-back characters incur exactly one idle cycle.
- Element counter wraps never: len is 1..5 and the index decrements to 0. Counter width CNT_W covers the 4-unit maximum.
- Simultaneous iVALID with oDONE: accepted (oREADY=1); the next LOAD follows.

Decomposition:
- Package morse_pkg holds:
  - state enum (IDLE, LOAD, MARK, SPACE, GAP, WORD);
  - unit-count constants DOT_U=1, DASH_U=3, ELEM_GAP_U=1, LETTER_GAP_U=3, WORD_EXTRA_U=4;
  - the pattern struct {len[2:0], bits[4:0], kind[1:0]}.
- Sub-module morse_rom: purely combinational ASCII -> pattern lookup (case fold, digits, space, invalid). The registering stays in morse_keyer.

Test Plan:
- UNIT_CYCLES=4, send 'E': oKEY high 4 cycles starting 2 cycles after transfer, then low 12 cycles, then a single oDONE pulse with oREADY=1.
- Send 'A' then 'e' back-to-back with iVALID held:
  - 'A' gives high 4 / low 4 / high 12 / low 12.
  - Second transfer occurs in the oDONE cycle.
  - 'e' matches the 'E' waveform.
- Send '0': five dashes (high 12 / low 4, repeated), trailing low 12; oBUSY=1 throughout, oREADY=0 until oDONE.
- Send ' ': oKEY stays 0, oBUSY=1 for 1 + 16 cycles, then oDONE.
- Send '#': no oKEY activity; oDONE pulses 2 cycles after transfer.
- Assert iRST_N=0 during the second unit of a dash in 'T': oKEY=0 within the same cycle (async); after release oREADY=1, oBUSY=0, no oDONE.
